// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// CLA_FLAGS_EN adds the cout/ovf/zero result flags.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
`ifdef CLA_FLAGS_EN
  logic             cout;
  logic             ovf;
  logic             zero;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum
`ifdef CLA_FLAGS_EN
    , input cout, ovf, zero
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum
`ifdef CLA_FLAGS_EN
    , output cout, ovf, zero
`endif
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SW-bit slice per stage.
// Define CLA_FLAGS_EN for registered cout/ovf/zero outputs.
module pipelined_cla_adder #(
  parameter int WIDTH            = 32,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int BPS = BLOCKS_PER_STAGE;
  localparam int SW  = (BLOCK * BPS > 0) ? BLOCK * BPS : 1;
  localparam int NS  = (WIDTH / SW > 0) ? WIDTH / SW : 1;

  if (WIDTH < 1 || BLOCK < 1 || BPS < 1 || (WIDTH % SW) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: illegal WIDTH/BLOCK/BLOCKS_PER_STAGE");
  end

  // returns {carry_out, sum} of one stage slice
  function automatic logic [SW:0] slice_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0]  g, p, c, s;
    logic [BPS-1:0] bg, bp;
    logic [BPS:0]   bc;
    logic           t, cb;
    g = x & y;
    p = x | y;
    for (int j = 0; j < BPS; j++) begin
      bg[j] = 1'b0;
      bp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        t = g[j*BLOCK+i];
        for (int m = i + 1; m < BLOCK; m++) t = t & p[j*BLOCK+m];
        bg[j] = bg[j] | t;
        bp[j] = bp[j] & p[j*BLOCK+i];
      end
    end
    for (int j = 0; j <= BPS; j++) begin
      t = ci;
      for (int m = 0; m < j; m++) t = t & bp[m];
      cb = t;
      for (int i = 0; i < j; i++) begin
        t = bg[i];
        for (int m = i + 1; m < j; m++) t = t & bp[m];
        cb = cb | t;
      end
      bc[j] = cb;
    end
    for (int j = 0; j < BPS; j++) begin
      for (int i = 0; i < BLOCK; i++) begin
        t = bc[j];
        for (int m = 0; m < i; m++) t = t & p[j*BLOCK+m];
        cb = t;
        for (int l = 0; l < i; l++) begin
          t = g[j*BLOCK+l];
          for (int m = l + 1; m < i; m++) t = t & p[j*BLOCK+m];
          cb = cb | t;
        end
        c[j*BLOCK+i] = cb;
      end
    end
    s = x ^ y ^ c;
    return {bc[BPS], s};
  endfunction

  logic             vld_q [NS];
  logic             vld_d [NS];
  logic [WIDTH-1:0] a_q   [NS];
  logic [WIDTH-1:0] a_d   [NS];
  logic [WIDTH-1:0] b_q   [NS];
  logic [WIDTH-1:0] b_d   [NS];
  logic [WIDTH-1:0] s_q   [NS];
  logic [WIDTH-1:0] s_d   [NS];
  logic             c_q   [NS];
  logic             c_d   [NS];
  logic             rdy   [NS];
  logic             va    [NS];
  logic [WIDTH-1:0] aa    [NS];
  logic [WIDTH-1:0] ba    [NS];
  logic [WIDTH-1:0] sa    [NS];
  logic             ca    [NS];
  logic [SW:0]      r;
`ifdef CLA_FLAGS_EN
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`endif

  always_comb begin
    rdy[NS-1] = !vld_q[NS-1] || bus.out_ready;
    for (int k = NS - 2; k >= 0; k--) rdy[k] = !vld_q[k] || rdy[k+1];
    va[0] = bus.in_valid;
    aa[0] = bus.a;
    ba[0] = bus.sub ? ~bus.b : bus.b;
    ca[0] = bus.sub | bus.cin;
    sa[0] = '0;
    for (int k = 1; k < NS; k++) begin
      va[k] = vld_q[k-1];
      aa[k] = a_q[k-1];
      ba[k] = b_q[k-1];
      ca[k] = c_q[k-1];
      sa[k] = s_q[k-1];
    end
    r = '0;
    for (int k = 0; k < NS; k++) begin
      vld_d[k] = rdy[k] ? va[k] : vld_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      s_d[k]   = s_q[k];
      c_d[k]   = c_q[k];
      r = slice_add(aa[k][k*SW +: SW], ba[k][k*SW +: SW], ca[k]);
      if (rdy[k] && va[k]) begin
        a_d[k] = aa[k];
        b_d[k] = ba[k];
        s_d[k] = sa[k];
        s_d[k][k*SW +: SW] = r[SW-1:0];
        c_d[k] = r[SW];
      end
    end
`ifdef CLA_FLAGS_EN
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (rdy[NS-1] && va[NS-1]) begin
      // same-sign operands giving a different-sign result
      ovf_d  = (aa[NS-1][WIDTH-1] == ba[NS-1][WIDTH-1]) &&
               (s_d[NS-1][WIDTH-1] != aa[NS-1][WIDTH-1]);
      zero_d = (s_d[NS-1] == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
`ifdef CLA_FLAGS_EN
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
`ifdef CLA_FLAGS_EN
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
`endif
    end
  end

  // consumed low operand bits and last-stage operands are dead
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < NS; k++) unused_bits = unused_bits ^ (^{a_q[k], b_q[k]});
`ifndef CLA_FLAGS_EN
    unused_bits = unused_bits ^ c_q[NS-1];
`endif
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_q[NS-1];
  assign bus.sum       = s_q[NS-1];
`ifdef CLA_FLAGS_EN
  assign bus.cout      = c_q[NS-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed steps plus randomized
// handshake traffic checked against an arithmetic reference queue.
module tb_pipelined_cla_adder;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  pipelined_cla_adder_if #(.WIDTH(32)) ifc ();

  pipelined_cla_adder #(
    .WIDTH(32),
    .BLOCK(4),
    .BLOCKS_PER_STAGE(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        ci,
    input logic        sb
  );
    exp_t        m;
    logic [31:0] be;
    logic [32:0] t;
    be     = sb ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {32'd0, (sb ? 1'b1 : ci)};
    m.sum  = t[31:0];
    m.cout = t[32];
    m.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
    m.zero = (t[31:0] == 32'd0);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs,
                     input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: accept pushes model result, output pops and compares
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
        chk("sb_expected_out", 33'(exp_q.size() != 0), 33'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_sum", 33'(ifc.sum), 33'(e.sum));
`ifdef CLA_FLAGS_EN
          chk("sb_flags", 33'({ifc.cout, ifc.ovf, ifc.zero}),
              33'({e.cout, e.ovf, e.zero}));
`endif
        end
      end
      if (ifc.in_valid === 1'b1 && ifc.in_ready === 1'b1)
        exp_q.push_back(model(ifc.a, ifc.b, ifc.cin, ifc.sub));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sb);
    logic acc;
    acc          = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.a        = a;
    ifc.b        = b;
    ifc.cin      = ci;
    ifc.sub      = sb;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = ifc.in_ready;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    chk("send_accepted", 33'(acc), 33'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ifc.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          idx;
    int          got;
    int          first_cyc;
    int          last_cyc;
    int          acc_n;
    int          issued;
    logic        seen;
    logic [31:0] ra;
    logic [31:0] rb;

    checks        = 0;
    failures      = 0;
    rst_n         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cin       = 1'b0;
    ifc.sub       = 1'b0;
    ifc.out_ready = 1'b0;

    // step 1: reset asserted mid-cycle clears outputs at once
    #12;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 33'(ifc.out_valid), 33'd0);
    chk("rst_sum", 33'(ifc.sum), 33'd0);
    chk("rst_in_ready", 33'(ifc.in_ready), 33'd1);
`ifdef CLA_FLAGS_EN
    chk("rst_flags", 33'({ifc.cout, ifc.ovf, ifc.zero}), 33'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // step 2: carry ripples through every stage
    ifc.out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out(lat);
    chk("ripple_latency", 33'(lat), 33'd4);
    chk("ripple_sum", 33'(ifc.sum), 33'd0);
`ifdef CLA_FLAGS_EN
    chk("ripple_flags", 33'({ifc.cout, ifc.ovf, ifc.zero}), 33'b101);
`endif
    @(posedge clk);
    #1;

    // step 3: subtraction
    send(32'd5, 32'd7, 1'b0, 1'b1);
    wait_out(lat);
    chk("sub_5m7_sum", 33'(ifc.sum), 33'h0_FFFF_FFFE);
`ifdef CLA_FLAGS_EN
    chk("sub_5m7_flags", 33'({ifc.cout, ifc.ovf, ifc.zero}), 33'b000);
`endif
    @(posedge clk);
    #1;
    send(32'h8000_0000, 32'd1, 1'b1, 1'b1);
    wait_out(lat);
    chk("sub_min_sum", 33'(ifc.sum), 33'h0_7FFF_FFFF);
`ifdef CLA_FLAGS_EN
    chk("sub_min_flags", 33'({ifc.cout, ifc.ovf, ifc.zero}), 33'b110);
`endif
    @(posedge clk);
    #1;

    // step 4: back-pressure fills four stages, then drains in order
    ifc.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      ifc.in_valid = 1'b1;
      ifc.a        = 32'(idx);
      ifc.b        = 32'(idx) << 1;
      ifc.cin      = 1'b0;
      ifc.sub      = 1'b0;
      @(negedge clk);
      if (ifc.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    chk("full_accepted", 33'(idx), 33'd4);
    chk("full_in_ready", 33'(ifc.in_ready), 33'd0);
    ifc.out_ready = 1'b1;
    got       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < 60 && got < 8; c++) begin
      ifc.in_valid = (idx < 8);
      ifc.a        = 32'(idx);
      ifc.b        = 32'(idx) << 1;
      @(negedge clk);
      if (ifc.out_valid) begin
        chk("stream_sum", 33'(ifc.sum), 33'(3 * got));
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got++;
      end
      if (ifc.in_valid && ifc.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    chk("stream_count", 33'(got), 33'd8);
    chk("stream_back_to_back", 33'(last_cyc - first_cyc), 33'd7);

    // step 5: reset with three beats in flight discards them
    for (int c = 0; c < 3; c++) begin
      ifc.in_valid = 1'b1;
      ifc.a        = 32'(100 + c);
      ifc.b        = 32'd1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 33'(ifc.out_valid), 33'd0);
    chk("midrst_sum", 33'(ifc.sum), 33'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ifc.out_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_output", 33'(seen), 33'd0);
    @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_out(lat);
    chk("midrst_new_latency", 33'(lat), 33'd4);
    chk("midrst_new_sum", 33'(ifc.sum), 33'h0_2345_6789);
    @(posedge clk);
    #1;

    // step 6: random traffic with random stalls on both sides
    acc_n  = 0;
    issued = 0;
    for (int c = 0; c < 60000 && !(acc_n == 10000 && exp_q.size() == 0); c++) begin
      if (!ifc.in_valid && issued < 10000 && $urandom_range(3) != 0) begin
        ra           = $urandom;
        rb           = $urandom;
        case ($urandom_range(3))
          0: rb = ~ra;
          1: rb = ra;
          default: ;
        endcase
        ifc.a        = ra;
        ifc.b        = rb;
        ifc.cin      = 1'($urandom_range(1));
        ifc.sub      = 1'($urandom_range(1));
        ifc.in_valid = 1'b1;
        issued++;
      end
      ifc.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      seen = ifc.in_valid && ifc.in_ready;
      if (seen) acc_n++;
      @(posedge clk);
      #1;
      if (seen) ifc.in_valid = 1'b0;
    end
    chk("rand_accepted", 33'(acc_n), 33'd10000);
    chk("rand_drained", 33'(exp_q.size()), 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
